// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared types for the memory bus arbiter and its transaction tracking FIFO.
package riscv_mem_arbiter_pkg;

    // Which requester a bus transaction belongs to
    typedef enum logic {
        MEM_SRC_IFU = 1'b0,
        MEM_SRC_LSU = 1'b1
    } mem_src_t;

    // One tracking entry per issued-but-unanswered bus transaction
    typedef struct packed {
        mem_src_t src;
        logic     drop;
    } mem_track_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_t;

    // Fetches always read a full word
    localparam logic [3:0] FETCH_BE = 4'hF;

    // Bits needed to hold the values 0..n inclusive
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/riscv_arb_fifo.sv
// Small synchronous FIFO of tracking entries; a flush marks every queued fetch as dropped.
module riscv_arb_fifo
    import riscv_mem_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CntW = cnt_width(DEPTH)
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            push_i,
    input  mem_track_t      push_data_i,
    input  logic            pop_i,
    input  logic            flush_ifu_i,
    output mem_track_t      head_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    mem_track_t      mem_q [DEPTH];
    logic [PtrW-1:0] wptr_q;
    logic [PtrW-1:0] rptr_q;
    logic [CntW-1:0] count_q;
    logic            push_ok;
    logic            pop_ok;
    mem_track_t      push_entry;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Qualify requests and fold a same-cycle flush into the incoming entry
    always_comb begin
        push_ok         = push_i && !full_o;
        pop_ok          = pop_i && !empty_o;
        push_entry      = push_data_i;
        push_entry.drop = push_data_i.drop ||
                          (flush_ifu_i && (push_data_i.src == MEM_SRC_IFU));
    end

    // Storage, pointers and occupancy
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (flush_ifu_i && (mem_q[i].src == MEM_SRC_IFU)) begin
                    mem_q[i].drop <= 1'b1;
                end
            end
            if (push_ok) begin
                mem_q[wptr_q] <= push_entry;
                wptr_q        <= next_ptr(wptr_q);
            end
            if (pop_ok) begin
                rptr_q <= next_ptr(rptr_q);
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + 1'b1;
            end else if (!push_ok && pop_ok) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign head_o  = mem_q[rptr_q];
    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one memory bus port between instruction fetch and load/store, routing
// in-order responses back to their requester and discarding fetches made stale by a redirect.
module riscv_mem_arbiter
    import riscv_mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned STARVE_LIMIT    = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        flush_i,
    input  logic        if_req_valid_i,
    output logic        if_req_ready_o,
    input  logic [29:0] if_addr_i,
    output logic        if_rsp_valid_o,
    output logic [31:0] if_rsp_data_o,
    input  logic        ls_req_valid_i,
    output logic        ls_req_ready_o,
    input  logic [29:0] ls_addr_i,
    input  logic        ls_we_i,
    input  logic [3:0]  ls_be_i,
    input  logic [31:0] ls_wdata_i,
    output logic        ls_rsp_valid_o,
    output logic [31:0] ls_rsp_data_o,
    output logic        bus_req_valid_o,
    input  logic        bus_req_ready_i,
    output logic [29:0] bus_addr_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_rsp_valid_i,
    input  logic [31:0] bus_rsp_data_i,
    output logic        err_o
);

    localparam int unsigned CntW = cnt_width(MAX_OUTSTANDING);
    localparam int unsigned StW  = cnt_width(STARVE_LIMIT);

    arb_state_t      state_q;
    mem_src_t        lock_src_q;
    logic [StW-1:0]  starve_q;
    logic            if_rsp_valid_q;
    logic [31:0]     if_rsp_data_q;
    logic            ls_rsp_valid_q;
    logic [31:0]     ls_rsp_data_q;
    logic            err_q;

    logic            space;
    mem_src_t        sel_src;
    logic            sel_valid;
    logic            req_valid;
    logic            handshake;
    logic            push;
    logic            pop;
    logic            head_drop;
    mem_track_t      push_data;
    mem_track_t      fifo_head;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CntW-1:0] fifo_count;

    // Requester selection, bus payload mux and request handshakes
    always_comb begin
        space   = (fifo_count < CntW'(MAX_OUTSTANDING));
        sel_src = MEM_SRC_LSU;
        if (state_q == ARB_LOCKED) begin
            sel_src = lock_src_q;
        end else if (if_req_valid_i && !flush_i &&
                     (!ls_req_valid_i || (starve_q == StW'(STARVE_LIMIT)))) begin
            sel_src = MEM_SRC_IFU;
        end
        sel_valid = (sel_src == MEM_SRC_IFU) ? if_req_valid_i : ls_req_valid_i;
        // Outputs must read 0 while reset is held, even with requesters active
        req_valid = !reset_i && space && sel_valid;
        handshake = req_valid && bus_req_ready_i;

        bus_req_valid_o = req_valid;
        bus_addr_o      = '0;
        bus_we_o        = 1'b0;
        bus_be_o        = '0;
        bus_wdata_o     = '0;
        if (req_valid) begin
            if (sel_src == MEM_SRC_IFU) begin
                bus_addr_o = if_addr_i;
                bus_be_o   = FETCH_BE;
            end else begin
                bus_addr_o  = ls_addr_i;
                bus_we_o    = ls_we_i;
                bus_be_o    = ls_be_i;
                bus_wdata_o = ls_wdata_i;
            end
        end
        if_req_ready_o = handshake && (sel_src == MEM_SRC_IFU);
        ls_req_ready_o = handshake && (sel_src == MEM_SRC_LSU);

        push           = handshake && !fifo_full;
        push_data.src  = sel_src;
        push_data.drop = flush_i && (sel_src == MEM_SRC_IFU);

        pop       = bus_rsp_valid_i && !fifo_empty;
        head_drop = fifo_head.drop || (flush_i && (fifo_head.src == MEM_SRC_IFU));
    end

    riscv_arb_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_track_fifo (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .flush_ifu_i (flush_i),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Lock the winner while the bus stalls so grant and payload stay stable
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ARB_IDLE;
            lock_src_q <= MEM_SRC_IFU;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (req_valid && !bus_req_ready_i) begin
                        state_q    <= ARB_LOCKED;
                        lock_src_q <= sel_src;
                    end
                end
                ARB_LOCKED: begin
                    if (handshake) begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    // Count LSU wins while a fetch is waiting; saturates at the limit
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            starve_q <= '0;
        end else if (!if_req_valid_i || if_req_ready_o) begin
            starve_q <= '0;
        end else if (ls_req_ready_o && (starve_q != StW'(STARVE_LIMIT))) begin
            starve_q <= starve_q + 1'b1;
        end
    end

    // Route each popped response to its requester one cycle later
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            if_rsp_valid_q <= 1'b0;
            if_rsp_data_q  <= '0;
            ls_rsp_valid_q <= 1'b0;
            ls_rsp_data_q  <= '0;
            err_q          <= 1'b0;
        end else begin
            if_rsp_valid_q <= pop && (fifo_head.src == MEM_SRC_IFU) && !head_drop;
            ls_rsp_valid_q <= pop && (fifo_head.src == MEM_SRC_LSU);
            if (pop && (fifo_head.src == MEM_SRC_IFU) && !head_drop) begin
                if_rsp_data_q <= bus_rsp_data_i;
            end
            if (pop && (fifo_head.src == MEM_SRC_LSU)) begin
                ls_rsp_data_q <= bus_rsp_data_i;
            end
            if (bus_rsp_valid_i && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    assign if_rsp_valid_o = if_rsp_valid_q;
    assign if_rsp_data_o  = if_rsp_data_q;
    assign ls_rsp_valid_o = ls_rsp_valid_q;
    assign ls_rsp_data_o  = ls_rsp_data_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed self-checking bench for riscv_mem_arbiter.
module tb_riscv_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        flush_i;
    logic        if_req_valid_i;
    logic        if_req_ready_o;
    logic [29:0] if_addr_i;
    logic        if_rsp_valid_o;
    logic [31:0] if_rsp_data_o;
    logic        ls_req_valid_i;
    logic        ls_req_ready_o;
    logic [29:0] ls_addr_i;
    logic        ls_we_i;
    logic [3:0]  ls_be_i;
    logic [31:0] ls_wdata_i;
    logic        ls_rsp_valid_o;
    logic [31:0] ls_rsp_data_o;
    logic        bus_req_valid_o;
    logic        bus_req_ready_i;
    logic [29:0] bus_addr_o;
    logic        bus_we_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_rsp_valid_i;
    logic [31:0] bus_rsp_data_i;
    logic        err_o;

    int n_cmp = 0;
    int n_err = 0;

    riscv_mem_arbiter #(
        .MAX_OUTSTANDING (2),
        .STARVE_LIMIT    (4)
    ) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .flush_i         (flush_i),
        .if_req_valid_i  (if_req_valid_i),
        .if_req_ready_o  (if_req_ready_o),
        .if_addr_i       (if_addr_i),
        .if_rsp_valid_o  (if_rsp_valid_o),
        .if_rsp_data_o   (if_rsp_data_o),
        .ls_req_valid_i  (ls_req_valid_i),
        .ls_req_ready_o  (ls_req_ready_o),
        .ls_addr_i       (ls_addr_i),
        .ls_we_i         (ls_we_i),
        .ls_be_i         (ls_be_i),
        .ls_wdata_i      (ls_wdata_i),
        .ls_rsp_valid_o  (ls_rsp_valid_o),
        .ls_rsp_data_o   (ls_rsp_data_o),
        .bus_req_valid_o (bus_req_valid_o),
        .bus_req_ready_i (bus_req_ready_i),
        .bus_addr_o      (bus_addr_o),
        .bus_we_o        (bus_we_o),
        .bus_be_o        (bus_be_o),
        .bus_wdata_o     (bus_wdata_o),
        .bus_rsp_valid_i (bus_rsp_valid_i),
        .bus_rsp_data_i  (bus_rsp_data_i),
        .err_o           (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset_i         = 1'b1;
        flush_i         = 1'b0;
        if_req_valid_i  = 1'b0;
        if_addr_i       = '0;
        ls_req_valid_i  = 1'b0;
        ls_addr_i       = '0;
        ls_we_i         = 1'b0;
        ls_be_i         = 4'hF;
        ls_wdata_i      = '0;
        bus_req_ready_i = 1'b1;
        bus_rsp_valid_i = 1'b0;
        bus_rsp_data_i  = '0;
        #2;
        check_eq("rst_bus_valid", bus_req_valid_o, 0);
        check_eq("rst_if_rsp", if_rsp_valid_o, 0);
        check_eq("rst_ls_rsp", ls_rsp_valid_o, 0);
        check_eq("rst_err", err_o, 0);
        tick();
        tick();
        reset_i = 1'b0;

        // Simultaneous requests: LSU first, then IFU; responses routed in order
        if_req_valid_i = 1'b1; if_addr_i = 30'h20;
        ls_req_valid_i = 1'b1; ls_addr_i = 30'h10;
        settle();
        check_eq("t1_ls_ready", ls_req_ready_o, 1);
        check_eq("t1_if_ready", if_req_ready_o, 0);
        check_eq("t1_addr_ls", bus_addr_o, 32'h10);
        tick();
        ls_req_valid_i = 1'b0;
        settle();
        check_eq("t1_if_ready2", if_req_ready_o, 1);
        check_eq("t1_addr_if", bus_addr_o, 32'h20);
        check_eq("t1_be_if", bus_be_o, 32'hF);
        check_eq("t1_we_if", bus_we_o, 0);
        tick();
        if_req_valid_i  = 1'b0;
        bus_rsp_valid_i = 1'b1; bus_rsp_data_i = 32'hAAAA0001;
        settle();
        check_eq("t1_ls_rsp_early", ls_rsp_valid_o, 0);
        tick();
        bus_rsp_data_i = 32'hBBBB0002;
        settle();
        check_eq("t1_ls_rsp", ls_rsp_valid_o, 1);
        check_eq("t1_ls_data", ls_rsp_data_o, 32'hAAAA0001);
        check_eq("t1_if_rsp_early", if_rsp_valid_o, 0);
        tick();
        bus_rsp_valid_i = 1'b0;
        settle();
        check_eq("t1_if_rsp", if_rsp_valid_o, 1);
        check_eq("t1_if_data", if_rsp_data_o, 32'hBBBB0002);
        check_eq("t1_ls_rsp_done", ls_rsp_valid_o, 0);
        tick();
        check_eq("t1_if_rsp_pulse", if_rsp_valid_o, 0);
        check_eq("t1_if_data_hold", if_rsp_data_o, 32'hBBBB0002);

        // Locked IFU request holds the bus through a stall
        bus_req_ready_i = 1'b0;
        if_req_valid_i  = 1'b1; if_addr_i = 30'h100;
        settle();
        check_eq("t2_lock_valid", bus_req_valid_o, 1);
        check_eq("t2_lock_addr", bus_addr_o, 32'h100);
        tick();
        ls_req_valid_i = 1'b1; ls_addr_i = 30'h200; ls_we_i = 1'b1;
        ls_be_i = 4'h3; ls_wdata_i = 32'hCAFE0003;
        for (int c = 0; c < 3; c++) begin
            settle();
            check_eq("t2_stall_addr", bus_addr_o, 32'h100);
            check_eq("t2_stall_we", bus_we_o, 0);
            check_eq("t2_stall_ls_rdy", ls_req_ready_o, 0);
            check_eq("t2_stall_if_rdy", if_req_ready_o, 0);
            tick();
        end
        bus_req_ready_i = 1'b1;
        settle();
        check_eq("t2_if_accept", if_req_ready_o, 1);
        check_eq("t2_ls_wait", ls_req_ready_o, 0);
        check_eq("t2_accept_addr", bus_addr_o, 32'h100);
        tick();
        if_req_valid_i = 1'b0;
        settle();
        check_eq("t2_ls_accept", ls_req_ready_o, 1);
        check_eq("t2_ls_addr", bus_addr_o, 32'h200);
        check_eq("t2_ls_we", bus_we_o, 1);
        check_eq("t2_ls_be", bus_be_o, 32'h3);
        check_eq("t2_ls_wdata", bus_wdata_o, 32'hCAFE0003);
        tick();
        ls_req_valid_i  = 1'b0; ls_we_i = 1'b0; ls_be_i = 4'hF;
        bus_rsp_valid_i = 1'b1; bus_rsp_data_i = 32'h11111111;
        tick();
        bus_rsp_data_i = 32'h22222222;
        settle();
        check_eq("t2_if_rsp", if_rsp_valid_o, 1);
        check_eq("t2_if_data", if_rsp_data_o, 32'h11111111);
        tick();
        bus_rsp_valid_i = 1'b0;
        settle();
        check_eq("t2_ls_rsp", ls_rsp_valid_o, 1);
        check_eq("t2_ls_data", ls_rsp_data_o, 32'h22222222);
        tick();

        // Starvation: four LSU wins, then IFU is forced through, then LSU again
        for (int k = 0; k < 7; k++) begin
            if_req_valid_i  = 1'b1; if_addr_i = 30'h400;
            ls_req_valid_i  = 1'b1; ls_addr_i = 30'h300 + 30'(k);
            bus_rsp_valid_i = (k > 0);
            bus_rsp_data_i  = 32'hC0000000 + 32'(k);
            settle();
            check_eq("t3_ls_ready", ls_req_ready_o, (k != 4) ? 32'd1 : 32'd0);
            check_eq("t3_if_ready", if_req_ready_o, (k == 4) ? 32'd1 : 32'd0);
            if (k == 6) begin
                check_eq("t3_if_rsp", if_rsp_valid_o, 1);
                check_eq("t3_if_data", if_rsp_data_o, 32'hC0000005);
            end
            tick();
        end
        if_req_valid_i  = 1'b0;
        ls_req_valid_i  = 1'b0;
        bus_rsp_valid_i = 1'b1;
        tick();
        bus_rsp_valid_i = 1'b0;
        tick();

        // Two fetches outstanding, flushed: no fetch responses, LSU still served
        if_req_valid_i = 1'b1; if_addr_i = 30'h40;
        settle();
        check_eq("t4_if_ready_a", if_req_ready_o, 1);
        tick();
        if_addr_i = 30'h44;
        settle();
        check_eq("t4_if_ready_b", if_req_ready_o, 1);
        tick();
        if_req_valid_i = 1'b0;
        flush_i        = 1'b1;
        tick();
        flush_i         = 1'b0;
        bus_rsp_valid_i = 1'b1; bus_rsp_data_i = 32'hDEAD0001;
        tick();
        bus_rsp_data_i = 32'hDEAD0002;
        settle();
        check_eq("t4_drop_a", if_rsp_valid_o, 0);
        tick();
        bus_rsp_valid_i = 1'b0;
        ls_req_valid_i  = 1'b1; ls_addr_i = 30'h80;
        settle();
        check_eq("t4_drop_b", if_rsp_valid_o, 0);
        check_eq("t4_ls_ready", ls_req_ready_o, 1);
        tick();
        ls_req_valid_i  = 1'b0;
        bus_rsp_valid_i = 1'b1; bus_rsp_data_i = 32'h5555AAAA;
        tick();
        bus_rsp_valid_i = 1'b0;
        settle();
        check_eq("t4_ls_rsp", ls_rsp_valid_o, 1);
        check_eq("t4_ls_data", ls_rsp_data_o, 32'h5555AAAA);
        check_eq("t4_no_if_rsp", if_rsp_valid_o, 0);
        tick();

        // Outstanding limit reached: nothing issues until a response frees space
        ls_req_valid_i = 1'b1; ls_addr_i = 30'h90;
        settle();
        check_eq("t5_fill_a", ls_req_ready_o, 1);
        tick();
        ls_addr_i = 30'h94;
        settle();
        check_eq("t5_fill_b", ls_req_ready_o, 1);
        tick();
        if_req_valid_i = 1'b1; ls_addr_i = 30'h98;
        settle();
        check_eq("t5_full_valid", bus_req_valid_o, 0);
        check_eq("t5_full_ls_rdy", ls_req_ready_o, 0);
        check_eq("t5_full_if_rdy", if_req_ready_o, 0);
        tick();
        bus_rsp_valid_i = 1'b1; bus_rsp_data_i = 32'h0;
        settle();
        check_eq("t5_no_bypass", bus_req_valid_o, 0);
        tick();
        bus_rsp_valid_i = 1'b0;
        settle();
        check_eq("t5_reissue", bus_req_valid_o, 1);
        check_eq("t5_reissue_rdy", ls_req_ready_o, 1);
        check_eq("t5_reissue_addr", bus_addr_o, 32'h98);
        tick();
        if_req_valid_i  = 1'b0;
        ls_req_valid_i  = 1'b0;
        bus_rsp_valid_i = 1'b1;
        tick();
        tick();
        bus_rsp_valid_i = 1'b0;
        tick();

        // Response with nothing outstanding sets sticky error
        check_eq("t6_err_before", err_o, 0);
        bus_rsp_valid_i = 1'b1; bus_rsp_data_i = 32'h77777777;
        tick();
        bus_rsp_valid_i = 1'b0;
        settle();
        check_eq("t6_err_set", err_o, 1);
        check_eq("t6_no_ls_rsp", ls_rsp_valid_o, 0);
        check_eq("t6_no_if_rsp", if_rsp_valid_o, 0);
        tick();
        check_eq("t6_err_sticky", err_o, 1);

        // Reset mid-transaction with an IFU request locked
        bus_req_ready_i = 1'b0;
        if_req_valid_i  = 1'b1; if_addr_i = 30'h100;
        tick();
        ls_req_valid_i = 1'b1; ls_addr_i = 30'h1F0;
        #2;
        reset_i = 1'b1;
        #1;
        check_eq("t6_rst_bus_valid", bus_req_valid_o, 0);
        check_eq("t6_rst_addr", bus_addr_o, 0);
        check_eq("t6_rst_if_rdy", if_req_ready_o, 0);
        check_eq("t6_rst_err", err_o, 0);
        tick();
        reset_i         = 1'b0;
        bus_req_ready_i = 1'b1;
        settle();
        check_eq("t6_post_ls_rdy", ls_req_ready_o, 1);
        check_eq("t6_post_if_rdy", if_req_ready_o, 0);
        check_eq("t6_post_addr", bus_addr_o, 32'h1F0);
        tick();
        if_req_valid_i = 1'b0;
        ls_req_valid_i = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
Shares the core's single memory bus port between the instruction fetch unit (IFU) and the load/store path fed by the EXU/MEM stage.
- Arbitrates requests, holds the granted request stable until the bus accepts it, and tracks outstanding transactions.
- Routes in-order responses back to the originating requester.
- Discards stale fetch responses after a branch redirect (branch_valid from EXU drives flush_i).

Parameters:
MAX_OUTSTANDING, 2, maximum issued-but-unanswered bus transactions (depth of tracking FIFO), must be >= 1
STARVE_LIMIT, 4, consecutive LSU wins while IFU waits before IFU is forced to win, must be >= 1

Ports:
clk_i  input  1  clock, all state on rising edge
reset_i  input  1  reset, asynchronous, active-high
flush_i  input  1  branch redirect; marks outstanding fetches as drop, blocks IFU grant this cycle
if_req_valid_i  input  1  IFU fetch request valid
if_req_ready_o  output  1  IFU request accepted this cycle
if_addr_i  input  30  IFU word address
if_rsp_valid_o  output  1  fetch response valid (registered)
if_rsp_data_o  output  32  fetch response data
ls_req_valid_i  input  1  load/store request valid
ls_req_ready_o  output  1  load/store request accepted this cycle
ls_addr_i  input  30  load/store word address
ls_we_i  input  1  write enable
ls_be_i  input  4  byte enables
ls_wdata_i  input  32  write data
ls_rsp_valid_o  output  1  load/store response valid (registered), also for writes
ls_rsp_data_o  output  32  load data
bus_req_valid_o  output  1  bus request valid
bus_req_ready_i  input  1  bus accepts request
bus_addr_o  output  30  bus word address
bus_we_o  output  1  bus write enable, 0 for fetches
bus_be_o  output  4  bus byte enables, 4'hF for fetches
bus_wdata_o  output  32  bus write data, 0 for fetches
bus_rsp_valid_i  input  1  bus response valid, in request order, one per accepted request
bus_rsp_data_i  input  32  bus response data
err_o  output  1  sticky: response received with no outstanding entry

Behaviour:
- Reset (async, while reset_i=1): all outputs 0; tracking FIFO empty; starvation counter 0; lock cleared; err_o cleared. Outstanding transactions are forgotten. A response arriving afterwards with an empty FIFO is ignored and sets err_o.
- Issue condition: space = (count < MAX_OUTSTANDING), using the pre-edge count. There is no pop bypass.
- States: IDLE and LOCKED.
  - IDLE: when space=1, select a requester combinationally.
    - Priority is LSU over IFU.
    - Exception: IFU wins if if_req_valid_i=1, starve count == STARVE_LIMIT and flush_i=0.
    - IFU is never selected while flush_i=1.
  - bus_req_valid_o = space && selected requester's valid. Bus payload is muxed from the selected requester.
  - If bus_req_valid_o=1 and bus_req_ready_i=0: go to LOCKED and latch the winner. The grant and payload stay fixed until bus_req_ready_i, even if the other requester asserts valid.
  - LOCKED: the latched requester drives the bus. If flush_i occurs while an IFU request is locked, it still completes; the resulting response is marked drop.
  - Handshake (bus_req_valid_o && bus_req_ready_i): winner's req_ready_o=1 that cycle; push {src, drop} to the FIFO. drop = flush_i && src==IFU. Return to IDLE.
  - Requester ready_o is 0 in every other case. Requesters must hold valid and payload until ready.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each LSU handshake while if_req_valid_i=1.
  - Clears on IFU handshake or when if_req_valid_i=0.
- Flush: every FIFO entry with src=IFU gets drop=1 at the edge. This applies to entries present before the edge and to a same-cycle IFU push.
- Response path:
  - On bus_rsp_valid_i with a non-empty FIFO: pop the head.
  - Next cycle, pulse the matching rsp_valid_o for one cycle with data registered from bus_rsp_data_i.
  - Dropped fetches produce no if_rsp_valid_o.
  - If a pop coincides with flush_i, the popping entry is also treated as dropped when src=IFU.
  - Simultaneous push and pop in the same cycle is legal; count is unchanged.
  - rsp_data outputs hold their last value when valid=0.
- Latency: request 0 cycles (combinational grant from valid when unlocked); response 1 cycle after bus_rsp_valid_i.

Decomposition:
- riscv_pkg additions:
  - typedef enum logic {MEM_SRC_IFU, MEM_SRC_LSU} mem_src_t
  - typedef struct packed {mem_src_t src; logic drop;} mem_track_t
  - arbiter state enum {ARB_IDLE, ARB_LOCKED}
- Sub-module riscv_arb_fifo: synchronous FIFO of mem_track_t.
  - Parameter DEPTH.
  - Ports: push, pop, full/empty, count.
  - Plus a flush_ifu input that sets drop on all IFU entries.

Test Plan:
- Both valid in the same cycle, bus_req_ready_i=1, empty FIFO -> LSU granted (ls_req_ready_o=1, if_req_ready_o=0). Next cycle with the LSU request dropped, IFU granted. Responses 0xAAAA0001 then 0xBBBB0002 appear on ls_rsp then if_rsp, each 1 cycle after bus_rsp_valid_i.
- Bus stalls 3 cycles with an IFU request locked (addr 0x100), then ls_req_valid_i rises -> bus_addr_o stays 0x100 and we=0 for all 3 cycles. IFU accepted on the ready cycle; LSU only afterwards.
- LSU valid every cycle and IFU valid, STARVE_LIMIT=4, bus always ready, MAX_OUTSTANDING large enough (or responses returned promptly so space stays 1) -> 4 LSU handshakes, then IFU granted on the 5th, then the counter clears.
- Two IFU fetches outstanding, flush_i pulsed, then 2 responses -> no if_rsp_valid_o. A following LSU response is still delivered with correct data.
- MAX_OUTSTANDING=2 filled, responses withheld -> bus_req_valid_o=0 and both ready_o=0. One response frees space; the next request issues the following cycle.
- bus_rsp_valid_i with empty FIFO -> no rsp_valid_o, err_o=1 and it stays set. reset_i asserted mid-transaction -> all outputs 0 immediately, err_o cleared.
